// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation and state encodings,
// default width and small operation-decode helpers.
package processor_defs;

   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CALC  = 2'b01,
      ST_FIXUP = 2'b10,
      ST_DONE  = 2'b11
   } md_state_t;

   // Divides have OP[1] set
   function automatic logic op_is_div(md_op_t op);
      return op[1];
   endfunction

   // Signed variants have OP[0] clear
   function automatic logic op_is_signed(md_op_t op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/md_iter_datapath.sv
// One-bit-per-cycle iteration engine on unsigned magnitudes.
// Multiply: {hi,lo} is a 2W shift-add accumulator, lo starts as the multiplier.
// Divide: restoring division, hi is the partial remainder and lo shifts the
// dividend out while the quotient bits shift in.
module md_iter_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_b;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_diff;
   logic             w_ge;

   // Next-step arithmetic, WIDTH+1 bits so the carry / borrow is kept
   always_comb begin
      w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_rem_sh = {r_hi, r_lo[WIDTH-1]};
      w_diff   = w_rem_sh - {1'b0, r_b};
      w_ge     = (w_rem_sh >= {1'b0, r_b});
   end

   // Load magnitudes on an accepted start, then one iteration per stepping cycle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_hi <= '0;
         r_lo <= '0;
         r_b  <= '0;
      end else if (i_load) begin
         r_hi <= '0;
         r_lo <= i_a;
         r_b  <= i_b;
      end else if (i_step) begin
         if (i_is_div) begin
            r_hi <= w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
         end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
         end
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers and MTHI/MTLO.
// Handshake: START is accepted only on a cycle where the FSM is IDLE (BUSY=0 and
// DONE=0); OP/SrcA/SrcB are captured on that edge only. DONE pulses one cycle
// when HI/LO carry the new result. MTHI/MTLO apply only in IDLE with START=0.
module mult_div_unit
   import processor_defs::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [1:0]       OP,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             WE_HI,
   input  logic             WE_LO,
   input  logic [WIDTH-1:0] WD,
   output logic             BUSY,
   output logic             DONE,
   output logic             DIV_ZERO,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output md_state_t        DBG_STATE
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   md_state_t        r_state;
   md_op_t           r_op;
   logic [CNT_W-1:0] r_cnt;
   logic             r_q_neg;
   logic             r_r_neg;
   logic             r_b_zero;
   logic             r_busy;
   logic             r_done;
   logic             r_div_zero;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   md_op_t           w_op;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_accept;
   logic [WIDTH-1:0] w_dp_hi;
   logic [WIDTH-1:0] w_dp_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_fix_hi;
   logic [WIDTH-1:0] w_fix_lo;

   // Operand magnitudes; unsigned ops pass raw values
   always_comb begin
      w_op     = md_op_t'(OP);
      w_a_neg  = op_is_signed(w_op) & SrcA[WIDTH-1];
      w_b_neg  = op_is_signed(w_op) & SrcB[WIDTH-1];
      w_a_mag  = w_a_neg ? -SrcA : SrcA;
      w_b_mag  = w_b_neg ? -SrcB : SrcB;
      w_accept = (r_state == ST_IDLE) && START;
   end

   md_iter_datapath #(.WIDTH(WIDTH)) u_dp (
      .CLK      (CLK),
      .RESET    (RESET),
      .i_load   (w_accept),
      .i_step   (r_state == ST_CALC),
      .i_is_div (op_is_div(w_accept ? w_op : r_op)),
      .i_a      (w_a_mag),
      .i_b      (w_b_mag),
      .o_hi     (w_dp_hi),
      .o_lo     (w_dp_lo)
   );

   // Sign fixup; divide by zero forces LO to all ones, HI recovers SrcA via r_neg
   always_comb begin
      w_prod   = {w_dp_hi, w_dp_lo};
      w_fix_hi = w_dp_hi;
      w_fix_lo = w_dp_lo;
      if (!op_is_div(r_op)) begin
         if (r_q_neg) w_prod = -w_prod;
         w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
         w_fix_lo = w_prod[WIDTH-1:0];
      end else begin
         if (r_q_neg)  w_fix_lo = -w_dp_lo;
         if (r_r_neg)  w_fix_hi = -w_dp_hi;
         if (r_b_zero) w_fix_lo = '1;
      end
   end

   // Control FSM with registered BUSY/DONE/DIV_ZERO and HI/LO ownership
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= ST_IDLE;
         r_op       <= MD_MULT;
         r_cnt      <= '0;
         r_q_neg    <= 1'b0;
         r_r_neg    <= 1'b0;
         r_b_zero   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (START) begin
                  r_op       <= w_op;
                  r_q_neg    <= w_a_neg ^ w_b_neg;
                  r_r_neg    <= w_a_neg;
                  r_b_zero   <= op_is_div(w_op) && (SrcB == '0);
                  r_cnt      <= '0;
                  r_div_zero <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_CALC;
               end else begin
                  if (WE_HI) r_hi <= WD;
                  if (WE_LO) r_lo <= WD;
               end
            end
            ST_CALC: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_ITER) r_state <= ST_FIXUP;
            end
            ST_FIXUP: begin
               r_hi       <= w_fix_hi;
               r_lo       <= w_fix_lo;
               r_div_zero <= r_b_zero;
               r_busy     <= 1'b0;
               r_done     <= 1'b1;
               r_state    <= ST_DONE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign DIV_ZERO  = r_div_zero;
   assign HI        = r_hi;
   assign LO        = r_lo;
   assign DBG_STATE = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations, each compared against a plain-arithmetic reference model.
module tb_mult_div_unit;
   import processor_defs::*;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic          CLK = 1'b0;
   logic          RESET;
   logic          START;
   logic [1:0]    OP;
   logic [W-1:0]  SrcA;
   logic [W-1:0]  SrcB;
   logic          WE_HI;
   logic          WE_LO;
   logic [W-1:0]  WD;
   logic          BUSY;
   logic          DONE;
   logic          DIV_ZERO;
   logic [W-1:0]  HI;
   logic [W-1:0]  LO;
   md_state_t     DBG_STATE;

   always #5 CLK = ~CLK;

   mult_div_unit #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .START     (START),
      .OP        (OP),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .WE_HI     (WE_HI),
      .WE_LO     (WE_LO),
      .WD        (WD),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .DIV_ZERO  (DIV_ZERO),
      .HI        (HI),
      .LO        (LO),
      .DBG_STATE (DBG_STATE)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   int             n_cmp = 0;
   int             n_err = 0;
   logic [2*W-1:0] exp_q[$];
   logic           exp_dz_q[$];
   logic [W-1:0]   m_hi = '0;
   logic [W-1:0]   m_lo = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the architectural definition
   task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      if (op[1] && b == '0) begin
         hi = a;
         lo = '1;
         dz = 1'b1;
      end else begin
         case (op)
            2'b00: p = sa * sb;
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
            default: p = {a % b, a / b};
         endcase
         hi = p[63:32];
         lo = p[31:0];
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noisy, input bit mtlo_with_start);
      logic [W-1:0]   eh, el;
      logic           ed;
      logic [2*W-1:0] e;
      int             cyc;
      model(op, a, b, eh, el, ed);
      exp_q.push_back({eh, el});
      exp_dz_q.push_back(ed);
      @(negedge CLK);
      START = 1'b1; OP = op; SrcA = a; SrcB = b;
      WE_HI = 1'b0; WE_LO = mtlo_with_start; WD = $urandom;
      @(negedge CLK);
      START = 1'b0; WE_LO = 1'b0; SrcA = $urandom; SrcB = $urandom; OP = 2'($urandom);
      cyc = 1;
      check("busy_after_start", BUSY, 1);
      check("dz_cleared_by_start", DIV_ZERO, 0);
      check("hilo_hold_at_start", {HI, LO}, {m_hi, m_lo});
      while (DONE !== 1'b1 && cyc < 100) begin
         if (noisy) begin
            START = 1'($urandom_range(0, 1));
            WE_HI = 1'($urandom_range(0, 1));
            WE_LO = 1'($urandom_range(0, 1));
            WD    = $urandom;
            OP    = 2'($urandom);
            SrcA  = $urandom;
            SrcB  = $urandom;
         end
         @(negedge CLK);
         cyc++;
         if (noisy && DONE !== 1'b1) check("hilo_hold_busy", {HI, LO}, {m_hi, m_lo});
      end
      START = 1'b0; WE_HI = 1'b0; WE_LO = 1'b0;
      e  = exp_q.pop_front();
      ed = exp_dz_q.pop_front();
      if (DONE !== 1'b1) begin
         check("done_timeout", 0, 1);
      end else begin
         check("latency", cyc, W + 2);
         check("hilo_result", {HI, LO}, e);
         check("div_zero", DIV_ZERO, ed);
         check("busy_in_done", BUSY, 0);
         m_hi = e[2*W-1:W];
         m_lo = e[W-1:0];
         @(negedge CLK);
         check("done_one_cycle", DONE, 0);
         check("hilo_hold_after", {HI, LO}, {m_hi, m_lo});
         check("div_zero_sticky", DIV_ZERO, ed);
      end
   endtask

   task automatic mt_write(input bit we_hi, input bit we_lo, input logic [W-1:0] d);
      @(negedge CLK);
      WE_HI = we_hi; WE_LO = we_lo; WD = d;
      @(negedge CLK);
      WE_HI = 1'b0; WE_LO = 1'b0; WD = $urandom;
      if (we_hi) m_hi = d;
      if (we_lo) m_lo = d;
      check("mt_hi", HI, m_hi);
      check("mt_lo", LO, m_lo);
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return '0;
         1:       return 32'd1;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      RESET = 1'b1; START = 1'b0; OP = 2'b00; SrcA = '0; SrcB = '0;
      WE_HI = 1'b0; WE_LO = 1'b0; WD = '0;
      repeat (3) @(negedge CLK);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_div_zero", DIV_ZERO, 0);
      check("rst_hilo", {HI, LO}, 0);
      check("rst_state", DBG_STATE, ST_IDLE);
      RESET = 1'b0;

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      run_op(2'b00, -32'sd7, 32'd6, 0, 0);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1, 0);
      run_op(2'b10, -32'sd7, 32'd2, 0, 0);
      run_op(2'b11, 32'd100, 32'd7, 0, 0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      run_op(2'b11, 32'd5, 32'd0, 0, 0);
      run_op(2'b10, -32'sd9, 32'd0, 1, 0);
      run_op(2'b01, 32'd3, 32'd5, 1, 1);
      run_op(2'b10, 32'd7, -32'sd2, 0, 1);

      mt_write(1, 0, 32'h0000_1234);
      mt_write(0, 1, 32'hCAFE_F00D);
      mt_write(1, 1, 32'h5A5A_A5A5);

      // reset in the middle of a multiply
      @(negedge CLK);
      START = 1'b1; OP = 2'b00; SrcA = $urandom; SrcB = $urandom;
      @(negedge CLK);
      START = 1'b0;
      repeat (9) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      check("midop_rst_busy", BUSY, 0);
      check("midop_rst_hilo", {HI, LO}, 0);
      check("midop_rst_done", DONE, 0);
      RESET = 1'b0;
      m_hi = '0;
      m_lo = '0;
      run_op(2'b01, 32'd12345, 32'd678, 0, 0);

      for (int i = 0; i < 40; i++) begin
         run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge CLK);
      check("idle_hold", {HI, LO}, {m_hi, m_lo});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
